crank_decoder: RTL and testbench
================================

Name: crank_decoder

Overview:
- Decodes the conditioned crank trigger-wheel signal from a missing-tooth wheel (default 36-1) into an absolute tooth index plus a one-cycle tooth-edge strobe.
- Sits directly upstream of every output_driver instance. Its tooth_num/tooth_edge pair is consumed by all fuel and ignition channels.
- Also publishes the last measured tooth period so angle-to-time scaling can compute start/end counts.

Parameters:
- TEETH_TOTAL, 36, tooth positions on the wheel, including missing ones (max 255).
- TEETH_MISSING, 1, consecutive missing teeth forming the sync gap (1 or 2).
- timer_length, 24, width of the period counter and of tooth_period.
- MIN_PERIOD, 16, minimum clk cycles between accepted edges; faster edges are noise and are ignored.
- STALL_COUNTS, 24'hFFFFFF, count at which the wheel is declared stopped.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- crank_in  in  1  conditioned crank sensor input, asynchronous to clk; the rising edge is the tooth event.
- tooth_num  out  8  current tooth index; 0 = first real tooth after the gap.
- tooth_edge  out  1  one-clk pulse per accepted tooth while synced; tooth_num is valid in the same cycle.
- synced  out  1  high while decoder is locked to the gap.
- sync_err  out  1  one-clk pulse when lock is lost (wrong gap position or stall).
- tooth_period  out  timer_length  clk cycles between the last two accepted edges.

Behaviour:
- Reset (async, active-high) values:
  - tooth_num=0, tooth_edge=0, synced=0, sync_err=0, tooth_period=0.
  - cnt=0, prev_period=0, state=STOPPED.
- Input conditioning:
  - crank_in passes through a 2-flop synchronizer, then a third flop for rising-edge detection.
  - raw_edge is therefore 3 clk after the crank_in rise.
  - All registered outputs update on the cycle after raw_edge: tooth_edge goes high 4 clk after the crank_in rise.
- cnt:
  - Increments every clk and saturates at STALL_COUNTS.
  - An accepted edge loads tooth_period<=cnt and cnt<=1. Edges P clk apart therefore give tooth_period=P.
- Edge acceptance: a raw_edge with cnt<MIN_PERIOD is discarded entirely. cnt is not reset, and there is no strobe and no state change.
- Gap test, evaluated on an accepted edge:
  - gap = (2*cnt > 3*prev_period).
  - Evaluate at timer_length+2 bits so there is no overflow.
- Only non-gap accepted edges update prev_period<=cnt. Gap periods never become the reference.
- STOPPED: first accepted edge -> WAIT_REF. No strobe.
- WAIT_REF: accepted edge -> prev_period<=cnt, go to SEEK_GAP. No strobe.
- SEEK_GAP:
  - accepted edge with gap -> tooth_num<=0, tooth_edge<=1, synced<=1, go to SYNCED.
  - non-gap edge -> update prev_period only; no strobe.
- SYNCED, accepted edge, with LAST = TEETH_TOTAL-TEETH_MISSING-1:
  - tooth_num==LAST and gap -> tooth_num<=0, tooth_edge<=1.
  - tooth_num!=LAST and no gap -> tooth_num<=tooth_num+1, tooth_edge<=1.
  - Any mismatch (gap early, or no gap at LAST) -> synced<=0, sync_err<=1, no tooth_edge, go to SEEK_GAP. For a no-gap mismatch, prev_period updates.
- Stall: in any state except STOPPED, when cnt reaches STALL_COUNTS:
  - state<=STOPPED, synced<=0, prev_period<=0.
  - sync_err<=1 only if synced was 1.
  - tooth_num holds its value. tooth_edge never fires from STOPPED.
- Simultaneous stall and accepted edge in the same cycle: the edge wins and the stall is ignored that cycle.
- tooth_edge and sync_err are never high in the same cycle. Each is at most one clk wide.
- tooth_num never exceeds LAST. Wrap from LAST to 0 occurs only on a confirmed gap.
- Reset asserted mid-rotation returns to STOPPED immediately. The decoder needs two edges plus a gap before tooth_edge resumes.

Test Plan:
- 36-1 wheel, 100 clk/tooth, gap edge 200 clk → strobes start after the first gap with tooth_num=0; counts 0..34 then wraps to 0; tooth_period=100 on normal teeth, 200 on the gap edge; synced=1 throughout.
- Start mid-wheel at tooth 10 → no tooth_edge before the first gap; first strobe is tooth_num=0; sync_err never asserts.
- While synced, insert an extra tooth (period 100) where the gap is expected → sync_err pulses 1 clk; synced=0; no strobe; strobes resume with tooth_num=0 after the next gap.
- While synced, inject a 5-clk glitch pulse between teeth → glitch ignored; tooth_period stays 100; tooth_num sequence unbroken.
- Stop edges with STALL_COUNTS=1000 → after 1000 clk of cnt: synced=0, single sync_err pulse, state STOPPED; restarting requires 2 edges plus a gap.
- Assert reset at tooth 20 → all outputs 0 asynchronously; after release the bench sees no strobe until a gap has been re-detected.

Source files
------------

// File: rtl/crank_decoder.sv
// Missing-tooth crank wheel decoder.
// Emits absolute tooth index, tooth strobe, lock state and tooth period.
module crank_decoder #(
  parameter int TEETH_TOTAL   = 36,
  parameter int TEETH_MISSING = 1,
  parameter int timer_length  = 24,
  parameter int MIN_PERIOD    = 16,
  parameter logic [timer_length-1:0] STALL_COUNTS =
    {timer_length{1'b1}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    crank_in,
  output logic [7:0]              tooth_num,
  output logic                    tooth_edge,
  output logic                    synced,
  output logic                    sync_err,
  output logic [timer_length-1:0] tooth_period
);

  localparam int W = timer_length + 2;
  localparam logic [7:0] LAST =
    8'(TEETH_TOTAL - TEETH_MISSING - 1);
  localparam logic [timer_length-1:0] MIN_P =
    timer_length'(MIN_PERIOD);

  typedef enum logic [1:0] {
    STOPPED,
    WAIT_REF,
    SEEK_GAP,
    SYNCED
  } state_t;

  state_t state, state_n;

  logic [2:0] sync_q;
  logic       raw_edge;

  logic [timer_length-1:0] cnt, cnt_n;
  logic [timer_length-1:0] prev_period, prev_n;
  logic [timer_length-1:0] per_n;
  logic [7:0]              num_n;
  logic                    edge_n, synced_n, err_n;

  logic         accept, stall, gap, at_last;
  logic [W-1:0] cnt2, prev3;

  // sync_q[2] holds the previous synchronized level for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      raw_edge <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], crank_in};
      raw_edge <= sync_q[1] & ~sync_q[2];
    end
  end

  assign accept  = raw_edge && (cnt >= MIN_P);
  assign stall   = (cnt == STALL_COUNTS) && (state != STOPPED);
  assign cnt2    = {1'b0, cnt, 1'b0};
  assign prev3   = {2'b00, prev_period}
                 + {1'b0, prev_period, 1'b0};
  assign gap     = cnt2 > prev3;
  assign at_last = tooth_num == LAST;

  always_comb begin
    state_n  = state;
    cnt_n    = (cnt == STALL_COUNTS) ? cnt : cnt + 1'b1;
    prev_n   = prev_period;
    per_n    = tooth_period;
    num_n    = tooth_num;
    edge_n   = 1'b0;
    synced_n = synced;
    err_n    = 1'b0;
    if (accept) begin
      cnt_n = timer_length'(1);
      per_n = cnt;
      unique case (state)
        STOPPED: state_n = WAIT_REF;
        WAIT_REF: begin
          prev_n  = cnt;
          state_n = SEEK_GAP;
        end
        SEEK_GAP: begin
          if (gap) begin
            num_n    = '0;
            edge_n   = 1'b1;
            synced_n = 1'b1;
            state_n  = SYNCED;
          end else begin
            prev_n = cnt;
          end
        end
        SYNCED: begin
          unique case (1'b1)
            (at_last && gap): begin
              num_n  = '0;
              edge_n = 1'b1;
            end
            (!at_last && !gap): begin
              num_n  = tooth_num + 8'd1;
              edge_n = 1'b1;
              prev_n = cnt;
            end
            default: begin
              // Gap seen early or missing at LAST: drop lock
              synced_n = 1'b0;
              err_n    = 1'b1;
              state_n  = SEEK_GAP;
              if (!gap) prev_n = cnt;
            end
          endcase
        end
        default: state_n = STOPPED;
      endcase
    end else if (stall) begin
      state_n  = STOPPED;
      synced_n = 1'b0;
      prev_n   = '0;
      err_n    = synced;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= STOPPED;
      cnt          <= '0;
      prev_period  <= '0;
      tooth_period <= '0;
      tooth_num    <= '0;
      tooth_edge   <= 1'b0;
      synced       <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      prev_period  <= prev_n;
      tooth_period <= per_n;
      tooth_num    <= num_n;
      tooth_edge   <= edge_n;
      synced       <= synced_n;
      sync_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_crank_decoder.sv
// Directed bench for crank_decoder on a 36-1 wheel.
// Strobes are logged and compared to hand-built tooth sequences.
module tb_crank_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        crank_in = 1'b0;
  logic [7:0]  tooth_num;
  logic        tooth_edge;
  logic        synced;
  logic        sync_err;
  logic [23:0] tooth_period;

  int nvec = 0;
  int nbad = 0;
  int nq[$];
  int pq[$];
  int eq_n[$];
  int eq_p[$];
  int errs = 0;
  int overlap = 0;

  crank_decoder #(
    .STALL_COUNTS(24'd1000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .crank_in    (crank_in),
    .tooth_num   (tooth_num),
    .tooth_edge  (tooth_edge),
    .synced      (synced),
    .sync_err    (sync_err),
    .tooth_period(tooth_period)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tooth_edge) begin
      nq.push_back(int'(tooth_num));
      pq.push_back(int'(tooth_period));
    end
    if (sync_err) begin
      errs++;
      if (tooth_edge) overlap++;
    end
  end

  task automatic chk(input string tag, input int obs,
                     input int exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic pulse(input int lo, input int hi);
    crank_in = 1'b0;
    repeat (lo) @(negedge clk);
    crank_in = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  // Rising edge lands p clk after the previous one
  task automatic tooth(input int p);
    pulse(p - 5, 5);
  endtask

  task automatic exp_add(input int n, input int p);
    eq_n.push_back(n);
    eq_p.push_back(p);
  endtask

  task automatic exp_run(input int a, input int b);
    for (int i = a; i <= b; i++) exp_add(i, 100);
  endtask

  task automatic compare_q(input string tag, input int s);
    chk({tag, "_count"}, nq.size() - s, eq_n.size());
    for (int i = 0; i < eq_n.size(); i++) begin
      if (s + i < nq.size()) begin
        chk($sformatf("%s_num%0d", tag, i),
            nq[s+i], eq_n[i]);
        chk($sformatf("%s_per%0d", tag, i),
            pq[s+i], eq_p[i]);
      end
    end
    eq_n.delete();
    eq_p.delete();
  endtask

  initial begin
    int s;
    int e0;

    repeat (3) @(negedge clk);
    chk("rst_num", int'(tooth_num), 0);
    chk("rst_edge", int'(tooth_edge), 0);
    chk("rst_synced", int'(synced), 0);
    chk("rst_err", int'(sync_err), 0);
    chk("rst_period", int'(tooth_period), 0);
    reset = 1'b0;

    // start mid-wheel at tooth 10
    s = nq.size();
    e0 = errs;
    tooth(50);
    repeat (24) tooth(100);
    tooth(200);
    repeat (34) tooth(100);
    tooth(200);
    repeat (5) tooth(100);
    exp_add(0, 200);
    exp_run(1, 34);
    exp_add(0, 200);
    exp_run(1, 5);
    compare_q("p1", s);
    chk("p1_err", errs - e0, 0);
    chk("p1_synced", int'(synced), 1);

    // extra tooth where the gap belongs
    s = nq.size();
    e0 = errs;
    repeat (29) tooth(100);
    tooth(100);
    chk("p2_lost", int'(synced), 0);
    chk("p2_err", errs - e0, 1);
    repeat (3) tooth(100);
    tooth(200);
    repeat (2) tooth(100);
    exp_run(6, 34);
    exp_add(0, 200);
    exp_run(1, 2);
    compare_q("p2", s);
    chk("p2_err_total", errs - e0, 1);
    chk("p2_synced", int'(synced), 1);

    // short glitch 10 clk after tooth 4
    s = nq.size();
    e0 = errs;
    tooth(100);
    tooth(100);
    pulse(5, 5);
    pulse(85, 5);
    tooth(100);
    tooth(100);
    exp_run(3, 7);
    compare_q("p3", s);
    chk("p3_err", errs - e0, 0);

    // stall
    s = nq.size();
    e0 = errs;
    crank_in = 1'b0;
    repeat (1100) @(negedge clk);
    chk("p4_err", errs - e0, 1);
    chk("p4_synced", int'(synced), 0);
    chk("p4_num_hold", int'(tooth_num), 7);
    chk("p4_strobes", nq.size() - s, 0);
    s = nq.size();
    e0 = errs;
    tooth(50);
    tooth(100);
    tooth(100);
    tooth(200);
    tooth(100);
    exp_add(0, 200);
    exp_add(1, 100);
    compare_q("p4r", s);
    chk("p4r_err", errs - e0, 0);

    // reset at tooth 20
    s = nq.size();
    repeat (19) tooth(100);
    exp_run(2, 20);
    compare_q("p5", s);
    crank_in = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_num", int'(tooth_num), 0);
    chk("arst_edge", int'(tooth_edge), 0);
    chk("arst_synced", int'(synced), 0);
    chk("arst_err", int'(sync_err), 0);
    chk("arst_period", int'(tooth_period), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    s = nq.size();
    e0 = errs;
    repeat (3) tooth(100);
    tooth(200);
    tooth(100);
    exp_add(0, 200);
    exp_add(1, 100);
    compare_q("p5r", s);
    chk("p5r_err", errs - e0, 0);

    chk("edge_err_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
